// File: rtl/pkt_meta_joiner.sv
// Pairs one metadata word with each packet and emits a registered stream with that meta on every beat.
// Optional PKT_META_LEN_CHECK_EN checks the packet byte length against a 16b field in meta.
module pkt_meta_joiner #(
   parameter int DATA_W  = 512,
   parameter int META_W  = 64,
   parameter int LEN_LSB = 0,
   localparam int EMPTY_W = $clog2(DATA_W/8)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_pkt_sop,
   input  logic               in_pkt_eop,
   input  logic [DATA_W-1:0]  in_pkt_data,
   input  logic [EMPTY_W-1:0] in_pkt_empty,
   input  logic               in_pkt_valid,
   output logic               in_pkt_ready,
   input  logic [META_W-1:0]  in_meta_data,
   input  logic               in_meta_valid,
   output logic               in_meta_ready,
   output logic               out_sop,
   output logic               out_eop,
   output logic [DATA_W-1:0]  out_data,
   output logic [EMPTY_W-1:0] out_empty,
   output logic [META_W-1:0]  out_meta,
   output logic               out_valid,
   input  logic               out_ready,
`ifdef PKT_META_LEN_CHECK_EN
   output logic               out_len_err,
`endif
   output logic [31:0]        stats_pkt,
   output logic [31:0]        stats_err
);

   typedef enum logic {IDLE, BODY} state_t;

   state_t state, state_nxt;
   logic   load_ok, load, join_sop, drop_err, sop_err, len_err;
   logic   pkt_acc;
   logic [1:0] err_inc;

   assign load_ok = ~out_valid | out_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (pkt_acc & in_pkt_sop & ~in_pkt_eop) state_nxt = BODY;
         BODY: if (pkt_acc & in_pkt_eop)               state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_pkt_ready  = 1'b0;
      in_meta_ready = 1'b0;
      pkt_acc       = 1'b0;
      load          = 1'b0;
      join_sop      = 1'b0;
      drop_err      = 1'b0;
      sop_err       = 1'b0;
      case (state)
         IDLE: begin
            // A sop beat is only taken together with its meta; orphan beats are swallowed.
            in_pkt_ready  = load_ok & (in_meta_valid | ~in_pkt_sop);
            in_meta_ready = load_ok & in_pkt_valid & in_pkt_sop & in_meta_valid;
            pkt_acc       = in_pkt_valid & in_pkt_ready;
            join_sop      = pkt_acc & in_pkt_sop;
            drop_err      = pkt_acc & ~in_pkt_sop;
            load          = join_sop;
         end
         BODY: begin
            in_pkt_ready = load_ok;
            pkt_acc      = in_pkt_valid & in_pkt_ready;
            load         = pkt_acc;
            sop_err      = pkt_acc & in_pkt_sop;
         end
         default: ;
      endcase
   end

`ifdef PKT_META_LEN_CHECK_EN
   localparam logic [15:0] BEAT_B = 16'(DATA_W/8);
   logic [15:0] byte_cnt, byte_sum, meta_len;

   always_comb begin
      byte_sum = (join_sop ? 16'd0 : byte_cnt)
               + (in_pkt_eop ? BEAT_B - 16'(in_pkt_empty) : BEAT_B);
      meta_len = join_sop ? in_meta_data[LEN_LSB +: 16] : out_meta[LEN_LSB +: 16];
      len_err  = load & in_pkt_eop & (byte_sum != meta_len);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt    <= '0;
         out_len_err <= 1'b0;
      end else if (load) begin
         byte_cnt    <= byte_sum;
         out_len_err <= len_err;
      end
   end
`else
   assign len_err = 1'b0;
`endif

   assign err_inc = {1'b0, drop_err} + {1'b0, sop_err} + {1'b0, len_err};

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         out_data  <= '0;
         out_empty <= '0;
         out_meta  <= '0;
         stats_pkt <= '0;
         stats_err <= '0;
      end else begin
         out_valid <= load | (out_valid & ~out_ready);
         if (load) begin
            // A sop seen inside a packet is passed through as a body beat.
            out_sop   <= in_pkt_sop & (state == IDLE);
            out_eop   <= in_pkt_eop;
            out_data  <= in_pkt_data;
            out_empty <= in_pkt_empty;
         end
         if (join_sop) begin
            out_meta  <= in_meta_data;
            stats_pkt <= stats_pkt + 32'd1;
         end
         stats_err <= stats_err + 32'(err_inc);
      end
   end

endmodule

// File: tb/tb_pkt_meta_joiner.sv
// Directed bench for pkt_meta_joiner: expected beats are queued at issue time and checked by a monitor.
module tb_pkt_meta_joiner;
   localparam int DW = 512, MW = 64, EW = 6;

   logic          clk = 1'b0, rst;
   logic          in_pkt_sop, in_pkt_eop, in_pkt_valid, in_pkt_ready;
   logic [DW-1:0] in_pkt_data;
   logic [EW-1:0] in_pkt_empty;
   logic [MW-1:0] in_meta_data;
   logic          in_meta_valid, in_meta_ready;
   logic          out_sop, out_eop, out_valid, out_ready, out_len_err;
   logic [DW-1:0] out_data;
   logic [EW-1:0] out_empty;
   logic [MW-1:0] out_meta;
   logic [31:0]   stats_pkt, stats_err;

   pkt_meta_joiner #(.DATA_W(DW), .META_W(MW), .LEN_LSB(0)) dut (
      .clk(clk), .rst(rst),
      .in_pkt_sop(in_pkt_sop), .in_pkt_eop(in_pkt_eop), .in_pkt_data(in_pkt_data),
      .in_pkt_empty(in_pkt_empty), .in_pkt_valid(in_pkt_valid), .in_pkt_ready(in_pkt_ready),
      .in_meta_data(in_meta_data), .in_meta_valid(in_meta_valid), .in_meta_ready(in_meta_ready),
      .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data), .out_empty(out_empty),
      .out_meta(out_meta), .out_valid(out_valid), .out_ready(out_ready),
`ifdef PKT_META_LEN_CHECK_EN
      .out_len_err(out_len_err),
`endif
      .stats_pkt(stats_pkt), .stats_err(stats_err)
   );

`ifndef PKT_META_LEN_CHECK_EN
   assign out_len_err = 1'b0;
`endif

   always #5 clk = ~clk;

   typedef struct {
      logic          sop, eop;
      logic [DW-1:0] data;
      logic [EW-1:0] empty;
      logic [MW-1:0] meta;
      logic          len_err;
   } beat_t;

   beat_t sb[$];
   int tests = 0, fails = 0;
   int exp_pkt = 0, exp_err = 0;

   function automatic logic [DW-1:0] dpat(int i);
      logic [DW-1:0] d;
      for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = 32'hD000_0000 + 32'(i*16 + k);
      return d;
   endfunction

   function automatic logic [MW-1:0] mk_meta(int tag, int len);
      return {48'hACE0_0000_0000 + 48'(tag), 16'(len)};
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_meta(logic [MW-1:0] m);
      in_meta_data  = m;
      in_meta_valid = 1'b1;
   endtask

   // Drive one beat until accepted; queue the expected output if it should be forwarded.
   task automatic send(bit sop, bit eop, int di, int empty, bit fwd, bit xsop, logic [MW-1:0] xmeta, bit xlen);
      bit acc = 0, mr = 0;
      int n = 0;
      beat_t e;
      in_pkt_sop   = sop;
      in_pkt_eop   = eop;
      in_pkt_data  = dpat(di);
      in_pkt_empty = EW'(empty);
      in_pkt_valid = 1'b1;
      if (fwd) begin
         e.sop = xsop; e.eop = eop; e.data = dpat(di); e.empty = EW'(empty);
         e.meta = xmeta; e.len_err = xlen;
         sb.push_back(e);
      end
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = in_pkt_ready;
         mr  = in_meta_ready;
         @(posedge clk);
         n++;
      end
      #1;
      in_pkt_valid = 1'b0;
      if (mr) in_meta_valid = 1'b0;
      if (!acc) begin
         tests++; fails++;
         $display("FAIL accept_timeout: beat %0d never accepted", di);
      end else if (fwd) chk("load_latency", out_valid, 1);
   endtask

   // Monitor: pop on every delivered beat; also verify registers hold during a stall.
   initial begin
      beat_t e;
      logic  held = 0;
      logic [DW+EW+MW+1:0] hv;
      forever begin
         @(negedge clk);
         if (held) chk("stall_hold", {63'd0, (hv == {out_sop, out_eop, out_data, out_empty, out_meta}) && out_valid}, 1);
         held = out_valid && !out_ready;
         hv   = {out_sop, out_eop, out_data, out_empty, out_meta};
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL unexpected_beat: got sop=%0b eop=%0b data0=%h, expected no beat", out_sop, out_eop, out_data[31:0]);
            end else begin
               e = sb.pop_front();
               if ({out_sop, out_eop, out_data, out_empty, out_meta} !== {e.sop, e.eop, e.data, e.empty, e.meta}
`ifdef PKT_META_LEN_CHECK_EN
                   || out_len_err !== e.len_err
`endif
               ) begin
                  fails++;
                  $display("FAIL beat: got sop=%0b eop=%0b empty=%0d meta=%h data0=%h lerr=%0b, expected sop=%0b eop=%0b empty=%0d meta=%h data0=%h lerr=%0b",
                           out_sop, out_eop, out_empty, out_meta, out_data[31:0], out_len_err,
                           e.sop, e.eop, e.empty, e.meta, e.data[31:0], e.len_err);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit pat [4] = '{1, 0, 0, 1};
      rst = 1; out_ready = 1;
      in_pkt_sop = 0; in_pkt_eop = 0; in_pkt_data = '0; in_pkt_empty = '0; in_pkt_valid = 0;
      in_meta_data = '0; in_meta_valid = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sop", out_sop, 0);
      chk("rst_out_meta", out_meta, 0);
      chk("rst_out_data", out_data[63:0], 0);
      chk("rst_stats_pkt", stats_pkt, 0);
      chk("rst_stats_err", stats_err, 0);
      @(posedge clk); #1 rst = 0;

      // 3-beat packet with meta ready
      set_meta(mk_meta(1, 192));
      send(1, 0, 1, 0, 1, 1, mk_meta(1, 192), 0);
      send(0, 0, 2, 0, 1, 0, mk_meta(1, 192), 0);
      send(0, 1, 3, 0, 1, 0, mk_meta(1, 192), 0);
      exp_pkt++;
      repeat (2) @(posedge clk);
      chk("t1_stats_pkt", stats_pkt, 32'(exp_pkt));
      chk("t1_stats_err", stats_err, 32'(exp_err));

      // sop waiting on late meta
      #1;
      in_pkt_sop = 1; in_pkt_eop = 1; in_pkt_data = dpat(4); in_pkt_empty = '0; in_pkt_valid = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_pkt_ready", in_pkt_ready, 0);
      end
      @(posedge clk); #1 set_meta(mk_meta(2, 64));
      #1 chk("meta_arrival_ready", in_pkt_ready, 1);
      send(1, 1, 4, 0, 1, 1, mk_meta(2, 64), 0);
      exp_pkt++;

      // back-to-back single-beat packets
      set_meta(mk_meta(3, 64));
      send(1, 1, 5, 0, 1, 1, mk_meta(3, 64), 0);
      set_meta(mk_meta(4, 64));
      send(1, 1, 6, 0, 1, 1, mk_meta(4, 64), 0);
      exp_pkt += 2;
      repeat (2) @(posedge clk);
      chk("t3_stats_pkt", stats_pkt, 32'(exp_pkt));
      chk("t3_stats_err", stats_err, 32'(exp_err));

      // orphan beat in IDLE, then a mid-packet sop
      #1 send(0, 1, 7, 0, 0, 0, '0, 0);
      exp_err++;
      @(negedge clk);
      chk("orphan_no_out", out_valid, 0);
      @(posedge clk); #1;
      set_meta(mk_meta(5, 192));
      send(1, 0, 8, 0, 1, 1, mk_meta(5, 192), 0);
      send(1, 0, 9, 0, 1, 0, mk_meta(5, 192), 0);
      send(0, 1, 10, 0, 1, 0, mk_meta(5, 192), 0);
      exp_pkt++; exp_err++;
      repeat (2) @(posedge clk);
      chk("t4_stats_pkt", stats_pkt, 32'(exp_pkt));
      chk("t4_stats_err", stats_err, 32'(exp_err));

      // backpressure 1,0,0,1 during a 4-beat packet
      #1 set_meta(mk_meta(6, 256));
      fork
         begin
            send(1, 0, 11, 0, 1, 1, mk_meta(6, 256), 0);
            send(0, 0, 12, 0, 1, 0, mk_meta(6, 256), 0);
            send(0, 0, 13, 0, 1, 0, mk_meta(6, 256), 0);
            send(0, 1, 14, 0, 1, 0, mk_meta(6, 256), 0);
         end
         begin
            for (int i = 0; i < 4; i++) begin
               out_ready = pat[i];
               @(posedge clk); #1;
            end
            out_ready = 1;
         end
      join
      exp_pkt++;
      repeat (3) @(posedge clk);
      chk("t5_stats_pkt", stats_pkt, 32'(exp_pkt));
      chk("t5_drained", 64'(sb.size()), 0);

`ifdef PKT_META_LEN_CHECK_EN
      // 64 + (64-28) = 100 matches; 64 + (64-20) = 108 does not
      #1 set_meta(mk_meta(7, 100));
      send(1, 0, 15, 0, 1, 1, mk_meta(7, 100), 0);
      send(0, 1, 16, 28, 1, 0, mk_meta(7, 100), 0);
      set_meta(mk_meta(8, 100));
      send(1, 0, 17, 0, 1, 1, mk_meta(8, 100), 0);
      send(0, 1, 18, 20, 1, 0, mk_meta(8, 100), 1);
      exp_pkt += 2; exp_err++;
      repeat (2) @(posedge clk);
      chk("len_stats_err", stats_err, 32'(exp_err));
`endif

      // reset mid-packet
      #1 set_meta(mk_meta(9, 192));
      send(1, 0, 19, 0, 1, 1, mk_meta(9, 192), 0);
      rst = 1;
      @(posedge clk); #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_stats_pkt", stats_pkt, 0);
      chk("midrst_stats_err", stats_err, 0);
      rst = 0;
      exp_pkt = 0; exp_err = 0;
      send(0, 1, 20, 0, 0, 0, '0, 0);
      exp_err++;
      set_meta(mk_meta(10, 64));
      send(1, 1, 21, 0, 1, 1, mk_meta(10, 64), 0);
      exp_pkt++;
      repeat (3) @(posedge clk);
      chk("post_rst_stats_pkt", stats_pkt, 32'(exp_pkt));
      chk("post_rst_stats_err", stats_err, 32'(exp_err));
      chk("final_drained", 64'(sb.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
